// File: rtl/mc_cu.sv
// Multicycle MIPS-style control unit: IF/ID/EXE/MEM/WB sequencer with combinational
// control outputs and a stall counter that stretches EXE for the multi-cycle hamdis op.
module mc_cu #(
    parameter int unsigned ALUC_W    = 4,
    parameter int unsigned HD_CYCLES = 4,
    parameter int unsigned EN_HAMDIS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic              z,
    input  logic              mem_rdy,
    output logic              wpc,
    output logic              wir,
    output logic              wmem,
    output logic              wreg,
    output logic              iord,
    output logic              m2reg,
    output logic              regrt,
    output logic              jal,
    output logic              shift,
    output logic              sext,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsource,
    output logic [ALUC_W-1:0] aluc,
    output logic [2:0]        state,
    output logic              illegal
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StExe = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    localparam logic [3:0] HdLoad = 4'(HD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] alu_op, alu4;

    logic r_type, r_add, r_sub, r_and, r_or, r_xor, r_sll, r_srl, r_sra, r_jr, r_ham;
    logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
    logic valid, imm_b;

    always_comb begin
        r_type = (op == 6'b000000);
        r_add  = r_type && (func == 6'b100000);
        r_sub  = r_type && (func == 6'b100010);
        r_and  = r_type && (func == 6'b100100);
        r_or   = r_type && (func == 6'b100101);
        r_xor  = r_type && (func == 6'b100110);
        r_sll  = r_type && (func == 6'b000000);
        r_srl  = r_type && (func == 6'b000010);
        r_sra  = r_type && (func == 6'b000011);
        r_jr   = r_type && (func == 6'b001000);
        r_ham  = r_type && (func == 6'b100111) && (EN_HAMDIS != 0);
        i_addi = (op == 6'b001000);
        i_andi = (op == 6'b001100);
        i_ori  = (op == 6'b001101);
        i_xori = (op == 6'b001110);
        i_lui  = (op == 6'b001111);
        i_lw   = (op == 6'b100011);
        i_sw   = (op == 6'b101011);
        i_beq  = (op == 6'b000100);
        i_bne  = (op == 6'b000101);
        i_j    = (op == 6'b000010);
        i_jal  = (op == 6'b000011);
        valid  = r_add | r_sub | r_and | r_or | r_xor | r_sll | r_srl | r_sra | r_jr | r_ham |
                 i_addi | i_andi | i_ori | i_xori | i_lui | i_lw | i_sw | i_beq | i_bne |
                 i_j | i_jal;
        imm_b  = i_addi | i_andi | i_ori | i_xori | i_lui | i_lw | i_sw;
    end

    always_comb begin
        alu_op = 4'b0000;
        if (r_sub || i_beq || i_bne) alu_op = 4'b0100;
        else if (r_and || i_andi)    alu_op = 4'b0001;
        else if (r_or || i_ori)      alu_op = 4'b0101;
        else if (r_xor || i_xori)    alu_op = 4'b0010;
        else if (i_lui)              alu_op = 4'b0110;
        else if (r_sll)              alu_op = 4'b0011;
        else if (r_srl)              alu_op = 4'b0111;
        else if (r_sra)              alu_op = 4'b1111;
        else if (r_ham)              alu_op = 4'b1011;
    end

    always_comb begin
        state_d  = StIf;
        cnt_d    = 4'd0;
        wpc      = 1'b0;
        wir      = 1'b0;
        wmem     = 1'b0;
        wreg     = 1'b0;
        iord     = 1'b0;
        m2reg    = 1'b0;
        regrt    = 1'b0;
        jal      = 1'b0;
        shift    = 1'b0;
        sext     = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsource = 2'b00;
        alu4     = 4'b0000;
        illegal  = 1'b0;
        case (state_q)
            StIf: begin
                alusrcb = 2'b01;
                wpc     = mem_rdy;
                wir     = mem_rdy;
                state_d = mem_rdy ? StId : StIf;
            end
            StId: begin
                // ALU computes the branch target here so EXE can use it from the ALU output reg
                alusrcb = 2'b11;
                if (!valid) begin
                    illegal = 1'b1;
                end else if (i_j) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                end else if (r_jr) begin
                    wpc      = 1'b1;
                    pcsource = 2'b10;
                end else if (i_jal) begin
                    wpc      = 1'b1;
                    pcsource = 2'b11;
                    wreg     = 1'b1;
                    jal      = 1'b1;
                end else begin
                    state_d = StExe;
                    cnt_d   = r_ham ? HdLoad : 4'd0;
                end
            end
            StExe: begin
                alusrca = 1'b1;
                alusrcb = imm_b ? 2'b10 : 2'b00;
                shift   = r_sll | r_srl | r_sra;
                sext    = i_addi | i_lw | i_sw | i_beq | i_bne;
                alu4    = alu_op;
                if (i_beq || i_bne) begin
                    pcsource = 2'b01;
                    wpc      = (i_beq & z) | (i_bne & ~z);
                end else if (cnt_q != 4'd0) begin
                    state_d = StExe;
                    cnt_d   = cnt_q - 4'd1;
                end else if (i_lw || i_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                iord = 1'b1;
                wmem = i_sw & mem_rdy;
                if (!mem_rdy)  state_d = StMem;
                else if (i_lw) state_d = StWb;
            end
            StWb: begin
                wreg  = 1'b1;
                m2reg = i_lw;
                regrt = i_addi | i_andi | i_ori | i_xori | i_lw | i_lui;
            end
            default: state_d = StIf;
        endcase
        // Reset forces IF, whose fetch strobes follow mem_rdy; mask them so nothing writes
        if (reset) begin
            wpc     = 1'b0;
            wir     = 1'b0;
            wmem    = 1'b0;
            wreg    = 1'b0;
            illegal = 1'b0;
        end
    end

    always_comb begin
        aluc      = '0;
        aluc[3:0] = alu4;
    end

    assign state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIf;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_cu.sv
// Self-checking bench for mc_cu: per-cycle expected control words are queued with the
// stimulus and compared against the DUT as each cycle is played out.
module tb_mc_cu;

    typedef logic [16:0] obs_t;  // {state, wpc, wir, wmem, wreg, illegal, jal, m2reg, regrt, pcs, alu}

    typedef struct {
        obs_t       v;
        obs_t       m;
        logic [5:0] op;
        logic [5:0] fn;
        logic       mr;
        logic       z;
    } exp_t;

    localparam obs_t M_BASE = 17'h1FE00;
    localparam obs_t M_SEL  = 17'h001C0;
    localparam obs_t M_PCS  = 17'h00030;
    localparam obs_t M_ALU  = 17'h0000F;

    localparam logic [5:0] R = 6'b000000;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] op    = 6'd0;
    logic [5:0] func  = 6'd0;
    logic       z     = 1'b0;
    logic       mem_rdy = 1'b0;

    logic       wpc_a, wir_a, wmem_a, wreg_a, iord_a, m2reg_a, regrt_a, jal_a, shift_a, sext_a;
    logic       alusrca_a, ill_a;
    logic [1:0] alusrcb_a, pcs_a;
    logic [3:0] aluc_a;
    logic [2:0] state_a;
    logic       wpc_b, wir_b, wmem_b, wreg_b, iord_b, m2reg_b, regrt_b, jal_b, shift_b, sext_b;
    logic       alusrca_b, ill_b;
    logic [1:0] alusrcb_b, pcs_b;
    logic [3:0] aluc_b;
    logic [2:0] state_b;

    obs_t obs_a, obs_b;
    assign obs_a = {state_a, wpc_a, wir_a, wmem_a, wreg_a, ill_a, jal_a, m2reg_a, regrt_a,
                    pcs_a, aluc_a};
    assign obs_b = {state_b, wpc_b, wir_b, wmem_b, wreg_b, ill_b, jal_b, m2reg_b, regrt_b,
                    pcs_b, aluc_b};

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mc_cu #(.ALUC_W(4), .HD_CYCLES(4), .EN_HAMDIS(1)) dut_a (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(wpc_a), .wir(wir_a), .wmem(wmem_a), .wreg(wreg_a), .iord(iord_a),
        .m2reg(m2reg_a), .regrt(regrt_a), .jal(jal_a), .shift(shift_a), .sext(sext_a),
        .alusrca(alusrca_a), .alusrcb(alusrcb_a), .pcsource(pcs_a), .aluc(aluc_a),
        .state(state_a), .illegal(ill_a)
    );

    mc_cu #(.ALUC_W(4), .HD_CYCLES(2), .EN_HAMDIS(0)) dut_b (
        .clock(clock), .reset(reset), .op(op), .func(func), .z(z), .mem_rdy(mem_rdy),
        .wpc(wpc_b), .wir(wir_b), .wmem(wmem_b), .wreg(wreg_b), .iord(iord_b),
        .m2reg(m2reg_b), .regrt(regrt_b), .jal(jal_b), .shift(shift_b), .sext(sext_b),
        .alusrca(alusrca_b), .alusrcb(alusrcb_b), .pcsource(pcs_b), .aluc(aluc_b),
        .state(state_b), .illegal(ill_b)
    );

    always #5 clock = ~clock;

    function automatic obs_t ob(input logic [2:0] st, input logic [4:0] str,
                                input logic [2:0] sel, input logic [1:0] pcs,
                                input logic [3:0] alu);
        return {st, str, sel, pcs, alu};
    endfunction

    function automatic void push(input logic [5:0] o, input logic [5:0] f, input logic mr,
                                 input logic zz, input obs_t v, input obs_t m);
        exp_t e;
        e.v  = v;
        e.m  = m | M_BASE;
        e.op = o;
        e.fn = f;
        e.mr = mr;
        e.z  = zz;
        sb.push_back(e);
    endfunction

    // Drive one cycle at the falling edge, sample after settling, advance a full clock.
    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic mr,
                        input logic zz, input bit use_b, output obs_t got);
        op = o; func = f; mem_rdy = mr; z = zz;
        #1;
        got = use_b ? obs_b : obs_a;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; mem_rdy = 1'b0;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t got;
        reset = 1'b1; mem_rdy = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        checks++;
        if ((obs_a & M_BASE) !== 17'h0) begin
            failures++;
            $display("FAIL reset_a got=%h want=%h", obs_a & M_BASE, 17'h0);
        end
        checks++;
        if ((obs_b & M_BASE) !== 17'h0) begin
            failures++;
            $display("FAIL reset_b got=%h want=%h", obs_b & M_BASE, 17'h0);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        got = obs_a & M_BASE;
        checks++;
        if (got !== ob(0, 5'b11000, 0, 0, 0)) begin
            failures++;
            $display("FAIL reset_release got=%h want=%h", got, ob(0, 5'b11000, 0, 0, 0));
        end
        mem_rdy = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_alu();
        exp_t e; obs_t got; int n = 0;
        push(R, 6'b100000, 1, 0, ob(0, 5'b11000, 0, 2'b00, 4'b0000), M_PCS | M_ALU);
        push(R, 6'b100000, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(R, 6'b100000, 0, 0, ob(2, 0, 0, 0, 4'b0000), M_ALU);
        push(R, 6'b100000, 0, 0, ob(4, 5'b00010, 3'b000, 0, 0), M_SEL);
        push(R, 6'b100000, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL add cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_lw();
        exp_t e; obs_t got; int n = 0;
        logic [5:0] o = 6'b100011;
        push(o, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(o, 0, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(o, 0, 0, 0, ob(2, 0, 0, 0, 4'b0000), M_ALU);
        push(o, 0, 0, 0, ob(3, 0, 0, 0, 0), 0);
        push(o, 0, 0, 0, ob(3, 0, 0, 0, 0), 0);
        push(o, 0, 1, 0, ob(3, 0, 0, 0, 0), 0);
        push(o, 0, 0, 0, ob(4, 5'b00010, 3'b011, 0, 0), M_SEL);
        push(o, 0, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL lw cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_branch();
        exp_t e; obs_t got; int n = 0;
        logic [5:0] ops [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
        logic       zs  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic       tk  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push(ops[i], 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
            push(ops[i], 0, 0, 0, ob(1, 0, 0, 0, 0), 0);
            push(ops[i], 0, 0, zs[i], ob(2, {tk[i], 4'b0000}, 0, 2'b01, 4'b0100),
                 M_ALU | (tk[i] ? M_PCS : 17'h0));
        end
        push(6'b000101, 0, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL branch cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_hamdis();
        exp_t e; obs_t got; int n = 0;
        push(R, 6'b100111, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(R, 6'b100111, 0, 0, ob(1, 0, 0, 0, 0), 0);
        repeat (4) push(R, 6'b100111, 0, 0, ob(2, 0, 0, 0, 4'b1011), M_ALU);
        push(R, 6'b100111, 0, 0, ob(4, 5'b00010, 3'b000, 0, 0), M_SEL);
        push(R, 6'b100111, 0, 0, ob(0, 0, 0, 0, 0), 0);
        // undecoded opcode: flagged in ID, straight back to IF
        push(6'b111111, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(6'b111111, 0, 0, 0, ob(1, 5'b00001, 0, 0, 0), 0);
        push(6'b111111, 0, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL hamdis cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_hamdis_disabled();
        exp_t e; obs_t got; int n = 0;
        push(R, 6'b100111, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(R, 6'b100111, 0, 0, ob(1, 5'b00001, 0, 0, 0), 0);
        push(R, 6'b100111, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b1, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL hamdis_off cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_jump();
        exp_t e; obs_t got; int n = 0;
        push(6'b000011, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(6'b000011, 0, 0, 0, ob(1, 5'b10010, 3'b100, 2'b11, 0), M_SEL | M_PCS);
        push(6'b000010, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(6'b000010, 0, 0, 0, ob(1, 5'b10000, 3'b000, 2'b11, 0), M_SEL | M_PCS);
        push(R, 6'b001000, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(R, 6'b001000, 0, 0, ob(1, 5'b10000, 3'b000, 2'b10, 0), M_SEL | M_PCS);
        push(R, 6'b001000, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL jump cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; obs_t got; int n = 0;
        logic [5:0] sw = 6'b101011;
        logic [5:0] addi = 6'b001000;
        push(sw, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(sw, 0, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(sw, 0, 0, 0, ob(2, 0, 0, 0, 4'b0000), M_ALU);
        push(sw, 0, 0, 0, ob(3, 0, 0, 0, 0), 0);
        push(sw, 0, 1, 0, ob(3, 5'b00100, 0, 0, 0), 0);
        push(R, 6'b100101, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(R, 6'b100101, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(R, 6'b100101, 0, 0, ob(2, 0, 0, 0, 4'b0101), M_ALU);
        push(R, 6'b100101, 0, 0, ob(4, 5'b00010, 3'b000, 0, 0), M_SEL);
        push(addi, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(addi, 0, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(addi, 0, 0, 0, ob(2, 0, 0, 0, 4'b0000), M_ALU);
        push(addi, 0, 0, 0, ob(4, 5'b00010, 3'b001, 0, 0), M_SEL);
        push(R, 6'b000011, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(R, 6'b000011, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(R, 6'b000011, 0, 0, ob(2, 0, 0, 0, 4'b1111), M_ALU);
        push(R, 6'b000011, 0, 0, ob(4, 5'b00010, 3'b000, 0, 0), M_SEL);
        push(R, 6'b000011, 0, 0, ob(0, 0, 0, 0, 0), 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL b2b cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
    endtask

    task automatic test_reset_in_mem();
        exp_t e; obs_t got; int n = 0;
        logic [5:0] sw = 6'b101011;
        push(sw, 0, 1, 0, ob(0, 5'b11000, 0, 0, 0), 0);
        push(sw, 0, 0, 0, ob(1, 0, 0, 0, 0), 0);
        push(sw, 0, 0, 0, ob(2, 0, 0, 0, 4'b0000), M_ALU);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            step(e.op, e.fn, e.mr, e.z, 1'b0, got);
            checks++;
            if ((got & e.m) !== (e.v & e.m)) begin
                failures++;
                $display("FAIL rst_mem cyc%0d got=%h want=%h", n, got & e.m, e.v & e.m);
            end
            n++;
        end
        mem_rdy = 1'b1;
        #1;
        got = obs_a & M_BASE;
        checks++;
        if (got !== ob(3, 5'b00100, 0, 0, 0)) begin
            failures++;
            $display("FAIL rst_mem_pre got=%h want=%h", got, ob(3, 5'b00100, 0, 0, 0));
        end
        reset = 1'b1;
        #1;
        got = obs_a & M_BASE;
        checks++;
        if (got !== 17'h0) begin
            failures++;
            $display("FAIL rst_mem_abort got=%h want=%h", got, 17'h0);
        end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        got = obs_a & M_BASE;
        checks++;
        if (got !== ob(0, 5'b11000, 0, 0, 0)) begin
            failures++;
            $display("FAIL rst_mem_release got=%h want=%h", got, ob(0, 5'b11000, 0, 0, 0));
        end
        @(posedge clock);
        #1;
        checks++;
        if (state_a !== 3'd1) begin
            failures++;
            $display("FAIL rst_mem_refetch got=%0d want=%0d", state_a, 1);
        end
        @(negedge clock);
        mem_rdy = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_lw();
        test_branch();
        test_hamdis();
        test_hamdis_disabled();
        do_reset();
        test_jump();
        test_back_to_back();
        test_reset_in_mem();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
